// File: rtl/stereo_addsub_pkg.sv
// Shared radio package: FSM state type, default sample width and the
// range check used by the add/sub saturation datapath.
package stereo_addsub_pkg;

  localparam int unsigned DEFAULT_DATA_SIZE = 32;
  localparam int unsigned MAX_W             = 64;

  typedef enum logic {READ, WRITE} state_t;

  typedef enum logic [1:0] {SAT_NONE, SAT_HI, SAT_LO} sat_t;

  // Classifies a sign-extended value against the signed range of 'width' bits.
  function automatic sat_t saturate(input logic signed [MAX_W:0] val,
                                    input int unsigned           width);
    logic signed [MAX_W:0] hi;
    logic signed [MAX_W:0] lo;
    hi = (65'sd1 <<< (width - 1)) - 65'sd1;
    lo = -(65'sd1 <<< (width - 1));
    if (val > hi) return SAT_HI;
    if (val < lo) return SAT_LO;
    return SAT_NONE;
  endfunction

endpackage

// File: rtl/stereo_addsub_sat.sv
// Add or subtract two samples at DATA_SIZE+1 bits, arithmetic shift, then
// clamp or wrap back to DATA_SIZE bits; 'clipped' flags an out-of-range result.
module addsub_sat
  import stereo_addsub_pkg::*;
#(
  parameter int DATA_SIZE = DEFAULT_DATA_SIZE,
  parameter int SHIFT     = 0,
  parameter int SATURATE  = 1,
  parameter int SUBTRACT  = 0
) (
  input  logic [DATA_SIZE-1:0] lpr,
  input  logic [DATA_SIZE-1:0] lmr,
  input  logic                 mono,
  output logic [DATA_SIZE-1:0] result,
  output logic                 clipped
);

  logic signed [DATA_SIZE:0] a_x, b_x, sum, shifted;
  logic signed [MAX_W:0]     wide;
  sat_t                      range;

  always_comb begin
    a_x = {lpr[DATA_SIZE-1], lpr};
    b_x = {lmr[DATA_SIZE-1], lmr};
    if (mono)               sum = a_x;
    else if (SUBTRACT != 0) sum = a_x - b_x;
    else                    sum = a_x + b_x;
    shifted = sum >>> SHIFT;
    wide    = {{(MAX_W - DATA_SIZE){shifted[DATA_SIZE]}}, shifted};
    range   = saturate(wide, DATA_SIZE);
    clipped = (range != SAT_NONE);
    result  = shifted[DATA_SIZE-1:0];
    if (SATURATE != 0) begin
      if (range == SAT_HI) result = {1'b0, {(DATA_SIZE - 1){1'b1}}};
      if (range == SAT_LO) result = {1'b1, {(DATA_SIZE - 1){1'b0}}};
    end
  end

endmodule

// File: rtl/stereo_addsub.sv
// Stereo matrix decoder: pops L+R / L-R pairs, writes left/right samples to
// two independent output FIFOs with one-cycle latency and full throughput.
module stereo_addsub
  import stereo_addsub_pkg::*;
#(
  parameter int DATA_SIZE = DEFAULT_DATA_SIZE,
  parameter int SHIFT     = 0,
  parameter int SATURATE  = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [DATA_SIZE-1:0] lmr_in_dout,
  input  logic                 lmr_in_empty,
  output logic                 lmr_in_rd_en,
  input  logic [DATA_SIZE-1:0] lpr_in_dout,
  input  logic                 lpr_in_empty,
  output logic                 lpr_in_rd_en,
  output logic [DATA_SIZE-1:0] left_out_din,
  input  logic                 left_out_full,
  output logic                 left_out_wr_en,
  output logic [DATA_SIZE-1:0] right_out_din,
  input  logic                 right_out_full,
  output logic                 right_out_wr_en,
  input  logic                 mono,
  output logic                 sat_flag
);

  state_t               state_q;
  logic [DATA_SIZE-1:0] left_q, right_q;
  logic                 ldone_q, rdone_q, sat_q;

  logic [DATA_SIZE-1:0] left_d, right_d;
  logic                 lclip, rclip;
  logic                 can_read, rd, l_wr, r_wr, l_fin, r_fin;

  addsub_sat #(
    .DATA_SIZE(DATA_SIZE), .SHIFT(SHIFT), .SATURATE(SATURATE), .SUBTRACT(0)
  ) u_left (
    .lpr(lpr_in_dout), .lmr(lmr_in_dout), .mono(mono),
    .result(left_d), .clipped(lclip)
  );

  addsub_sat #(
    .DATA_SIZE(DATA_SIZE), .SHIFT(SHIFT), .SATURATE(SATURATE), .SUBTRACT(1)
  ) u_right (
    .lpr(lpr_in_dout), .lmr(lmr_in_dout), .mono(mono),
    .result(right_d), .clipped(rclip)
  );

  // Handshakes are gated by reset so a pending pair is dropped, never written.
  always_comb begin
    can_read = !lmr_in_empty && !lpr_in_empty;
    l_wr     = !reset && (state_q == WRITE) && !ldone_q && !left_out_full;
    r_wr     = !reset && (state_q == WRITE) && !rdone_q && !right_out_full;
    l_fin    = ldone_q || l_wr;
    r_fin    = rdone_q || r_wr;
    rd       = !reset && can_read &&
               ((state_q == READ) || (l_fin && r_fin));
  end

  assign lmr_in_rd_en    = rd;
  assign lpr_in_rd_en    = rd;
  assign left_out_wr_en  = l_wr;
  assign right_out_wr_en = r_wr;
  assign left_out_din    = l_wr ? left_q  : '0;
  assign right_out_din   = r_wr ? right_q : '0;
  assign sat_flag        = sat_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= READ;
      left_q  <= '0;
      right_q <= '0;
      ldone_q <= 1'b0;
      rdone_q <= 1'b0;
      sat_q   <= 1'b0;
    end else if (rd) begin
      state_q <= WRITE;
      left_q  <= left_d;
      right_q <= right_d;
      ldone_q <= 1'b0;
      rdone_q <= 1'b0;
      sat_q   <= sat_q | lclip | rclip;
    end else if (state_q == WRITE) begin
      if (l_wr) ldone_q <= 1'b1;
      if (r_wr) rdone_q <= 1'b1;
      if (l_fin && r_fin) state_q <= READ;
    end
  end

endmodule

// File: doc/stereo_addsub.md
STEREO_ADDSUB -- requirements
Module: stereo_addsub

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 32, sample width in bits (two's complement).
REQ-002 SHALL have parameter SHIFT, default 0, arithmetic right shift applied to each result (0..DATA_SIZE-1).
REQ-003 SHALL have parameter SATURATE, default 1; 1 = clamp results to DATA_SIZE range, 0 = wrap (truncate).
REQ-004 SHALL have port clock  in  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have ports lmr_in_dout in DATA_SIZE, lmr_in_empty in 1, lmr_in_rd_en out 1: the L-R input FIFO read side.
REQ-007 SHALL have ports lpr_in_dout in DATA_SIZE, lpr_in_empty in 1, lpr_in_rd_en out 1: the L+R input FIFO read side.
REQ-008 SHALL have ports left_out_din out DATA_SIZE, left_out_full in 1, left_out_wr_en out 1: the left output FIFO write side.
REQ-009 SHALL have ports right_out_din out DATA_SIZE, right_out_full in 1, right_out_wr_en out 1: the right output FIFO write side.
REQ-010 SHALL have port mono  in  1  1 = mono mode; sampled on the cycle a pair is read.
REQ-011 SHALL have port sat_flag  out  1  sticky; set when any result has clamped (SATURATE=1) or wrapped (SATURATE=0).

Function
REQ-012 SHALL use the FSM states READ and WRITE; reset state is READ.
REQ-013 In READ, when both empty flags are 0, SHALL assert both rd_en for one cycle, register both results, clear the per-output done flags and go to WRITE; otherwise it SHALL assert no rd_en and stay in READ.
REQ-014 SHALL never read one input FIFO without the other; the rd_en pair is always equal.
REQ-015 In stereo mode, left SHALL be (lpr + lmr) >>> SHIFT and right SHALL be (lpr - lmr) >>> SHIFT, each computed at DATA_SIZE+1 bits before shifting.
REQ-016 In mono mode, left and right SHALL both be lpr >>> SHIFT; lmr is still consumed and discarded.
REQ-017 With SATURATE=1, a shifted result above 2^(DATA_SIZE-1)-1 or below -2^(DATA_SIZE-1) SHALL clamp to that bound; with SATURATE=0, it SHALL keep the low DATA_SIZE bits.
REQ-018 In WRITE, each output SHALL assert wr_en with its registered result when its full is 0 and its done flag is 0, then set its done flag; the two outputs are independent.
REQ-019 When one output is full, the other SHALL still write; the full output retries each cycle with its data held stable.
REQ-020 din SHALL be 0 whenever the matching wr_en is 0.
REQ-021 When both outputs complete in the current cycle (done or writing now) and both inputs are non-empty, SHALL read the next pair in the same cycle and stay in WRITE (throughput one pair per cycle).
REQ-022 When both outputs complete and an input is empty, SHALL return to READ.
REQ-023 Latency SHALL be one cycle: a pair read in cycle N appears on wr_en in cycle N+1 if neither output is full.
REQ-024 No output SHALL be written twice per pair, and no pair SHALL be dropped.
REQ-025 sat_flag SHALL set in the cycle after the read whose result clamped or wrapped, and SHALL clear only on reset.

Reset
REQ-026 reset SHALL force state READ, clear results, done flags and sat_flag to 0, and drive all rd_en and wr_en to 0 and all din to 0 on the next edge.
REQ-027 Reset asserted mid-WRITE SHALL abandon the pending pair without writing it.

Structure
REQ-028 The state enum, the saturate function and the default width constant SHALL live in the shared radio package.
REQ-029 The add/sub, shift and saturate datapath SHALL be one sub-module, addsub_sat, instantiated twice (add for left, subtract for right).

Verification
REQ-030 Stereo: lpr=1000, lmr=200 -> left=1200, right=800, both wr_en in cycle N+1, sat_flag=0.
REQ-031 Saturate: lpr=0x7FFFFFF0, lmr=0x20, SATURATE=1 -> left=0x7FFFFFFF, right=0x7FFFFFD0, sat_flag=1; with SATURATE=0 -> left=0x80000010.
REQ-032 Backpressure: right_out_full=1 for 5 cycles -> left written once immediately; right written once after full drops; no reads until then.
REQ-033 Streaming: 8 pairs, inputs never empty, outputs never full -> 8 consecutive cycles with both wr_en high.
REQ-034 Mono with SHIFT=1: lpr=-6, lmr=100 -> left=right=-3.
REQ-035 Reset during WRITE with left full -> no write occurs; next pair is processed normally and sat_flag=0.
